// File: rtl/registrador_pisos.sv
// Elevator request register: latches hall and car button press edges and clears them as the car serves a floor.
// Optional macro REGISTRADOR_CANCELAR_EN: a new press on an already latched car button cancels that request.
module registrador_pisos #(
    parameter  int NPISOS = 4,
    localparam int PW     = $clog2(NPISOS),
    localparam int CW     = $clog2(3*NPISOS+1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NPISOS-1:0] sube,
    input  logic [NPISOS-1:0] baja,
    input  logic [NPISOS-1:0] cabina,
    input  logic [PW-1:0]     piso_actual,
    input  logic              atender,
    input  logic              direccion,
    output logic [NPISOS-1:0] req_sube,
    output logic [NPISOS-1:0] req_baja,
    output logic [NPISOS-1:0] req_cabina,
    output logic              hay_arriba,
    output logic              hay_abajo,
    output logic              hay_aqui,
    output logic [CW-1:0]     pendientes
);

    // The top floor has no up button and the ground floor has no down button.
    localparam logic [NPISOS-1:0] SUBE_MASK = {NPISOS{1'b1}} >> 1;
    localparam logic [NPISOS-1:0] BAJA_MASK = {NPISOS{1'b1}} << 1;

    logic [NPISOS-1:0] prev_sube, prev_baja, prev_cabina;
    logic [NPISOS-1:0] edge_sube, edge_baja, edge_cabina;
    logic [NPISOS-1:0] sel, clr_sube, clr_baja, clr_cabina;
    logic [NPISOS-1:0] sube_d, baja_d, cabina_d, todos_d;
    logic              valido, extremo, servir;
    logic              arriba_d, abajo_d, aqui_d;

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
        arriba_d = 1'b0;
        abajo_d  = 1'b0;
        aqui_d   = 1'b0;

        valido  = {1'b0, piso_actual} < (PW+1)'(NPISOS);
        extremo = (piso_actual == '0) || (piso_actual == PW'(NPISOS-1));
        servir  = atender && valido;
        sel     = valido ? (NPISOS'(1) << piso_actual) : '0;

        clr_cabina = servir ? sel : '0;
        clr_sube   = (servir && (direccion || extremo))  ? sel : '0;
        clr_baja   = (servir && (!direccion || extremo)) ? sel : '0;

        edge_sube   = sube   & ~prev_sube;
        edge_baja   = baja   & ~prev_baja;
        edge_cabina = cabina & ~prev_cabina;

        // A clear always beats a press on the same bit.
        sube_d = (req_sube | edge_sube) & ~clr_sube & SUBE_MASK;
        baja_d = (req_baja | edge_baja) & ~clr_baja & BAJA_MASK;
`ifdef REGISTRADOR_CANCELAR_EN
        cabina_d = (req_cabina ^ edge_cabina) & ~clr_cabina;
`else
        cabina_d = (req_cabina | edge_cabina) & ~clr_cabina;
`endif

        todos_d = sube_d | baja_d | cabina_d;
        for (int i = 0; i < NPISOS; i++) begin
            if (todos_d[i]) begin
                if (i > int'(piso_actual)) arriba_d = 1'b1;
                if (i < int'(piso_actual)) abajo_d  = 1'b1;
                if (i == int'(piso_actual)) aqui_d  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            prev_sube   <= '0;
            prev_baja   <= '0;
            prev_cabina <= '0;
            req_sube    <= '0;
            req_baja    <= '0;
            req_cabina  <= '0;
            hay_arriba  <= 1'b0;
            hay_abajo   <= 1'b0;
            hay_aqui    <= 1'b0;
            pendientes  <= '0;
        end else begin
            prev_sube   <= sube;
            prev_baja   <= baja;
            prev_cabina <= cabina;
            req_sube    <= sube_d;
            req_baja    <= baja_d;
            req_cabina  <= cabina_d;
            hay_arriba  <= arriba_d;
            hay_abajo   <= abajo_d;
            hay_aqui    <= aqui_d;
            pendientes  <= CW'($countones({sube_d, baja_d, cabina_d}));
        end
    end

endmodule
